// File: rtl/edge_timing_counter_if.sv
// Bundle of channel inputs, global controls and measurement outputs
// for edge_timing_counter.
interface edge_timing_counter_if #(
  parameter int CH = 2,
  parameter int W  = 16
);
  logic [CH-1:0]   X;
  logic            EN;
  logic            CLR;
  logic            SAT;
  logic [1:0]      MODE;
  logic [CH-1:0]   Q;
  logic [CH-1:0]   EDGE;
  logic [CH*W-1:0] CNT;
  logic [CH*W-1:0] PER;
  logic [CH-1:0]   PV;
  logic [CH-1:0]   OVF;

  modport master (
    output X, EN, CLR, SAT, MODE,
    input  Q, EDGE, CNT, PER, PV, OVF
  );

  modport slave (
    input  X, EN, CLR, SAT, MODE,
    output Q, EDGE, CNT, PER, PV, OVF
  );
endinterface

// File: rtl/edge_timing_counter.sv
// Multi-channel synchronise / edge-qualify / count / period-measure
// unit for asynchronous external strobes.
module edge_timing_counter #(
  parameter int CH   = 2,
  parameter int W    = 16,
  parameter int SYNC = 2
) (
  input logic CLK,
  input logic R,
  edge_timing_counter_if.slave bus
);

  localparam logic [W-1:0] MAX = '1;

  logic [CH-1:0]   q_w;
  logic [CH-1:0]   edge_w;
  logic [CH-1:0]   pv_w;
  logic [CH-1:0]   ovf_w;
  logic [CH*W-1:0] cnt_w;
  logic [CH*W-1:0] per_w;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC-1:0] sync_q;
    logic            prev_q;
    logic [W-1:0]    cnt_q;
    logic [W-1:0]    cnt_d;
    logic [W-1:0]    tmr_q;
    logic [W-1:0]    tmr_d;
    logic [W-1:0]    per_q;
    logic [W-1:0]    per_d;
    logic            seen_q;
    logic            seen_d;
    logic            pv_q;
    logic            pv_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            q;
    logic            rise;
    logic            fall;
    logic            ev;

    assign q    = sync_q[SYNC-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

    always_comb begin
      ev = 1'b0;
      unique case (bus.MODE)
        2'b00: ev = rise;
        2'b01: ev = fall;
        2'b10: ev = rise | fall;
        2'b11: ev = q;
      endcase
    end

    // Sync chain and prev reg run free of EN/CLR/MODE.
    always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC-2:0], bus.X[i]};
        prev_q <= q;
      end
    end

    always_comb begin
      cnt_d  = cnt_q;
      tmr_d  = tmr_q;
      per_d  = per_q;
      seen_d = seen_q;
      pv_d   = pv_q;
      ovf_d  = ovf_q;
      if (bus.CLR) begin
        cnt_d  = '0;
        tmr_d  = '0;
        per_d  = '0;
        seen_d = 1'b0;
        pv_d   = 1'b0;
        ovf_d  = 1'b0;
      end else if (bus.EN) begin
        if (ev) begin
          if (cnt_q == MAX) begin
            ovf_d = 1'b1;
            cnt_d = bus.SAT ? MAX : '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // Timer counts idle cycles, so the event cycle adds one.
          per_d  = (tmr_q == MAX) ? MAX : tmr_q + 1'b1;
          tmr_d  = '0;
          seen_d = 1'b1;
          pv_d   = pv_q | seen_q;
        end else if (tmr_q != MAX) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
        cnt_q  <= '0;
        tmr_q  <= '0;
        per_q  <= '0;
        seen_q <= 1'b0;
        pv_q   <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tmr_q  <= tmr_d;
        per_q  <= per_d;
        seen_q <= seen_d;
        pv_q   <= pv_d;
        ovf_q  <= ovf_d;
      end
    end

    assign q_w[i]            = q;
    assign edge_w[i]         = ev & bus.EN;
    assign pv_w[i]           = pv_q;
    assign ovf_w[i]          = ovf_q;
    assign cnt_w[i*W +: W]   = cnt_q;
    assign per_w[i*W +: W]   = per_q;
  end

  assign bus.Q    = q_w;
  assign bus.EDGE = edge_w;
  assign bus.PV   = pv_w;
  assign bus.OVF  = ovf_w;
  assign bus.CNT  = cnt_w;
  assign bus.PER  = per_w;

endmodule

// File: tb/tb_edge_timing_counter.sv
// Randomised and directed bench for edge_timing_counter against an
// event-level reference model.
module tb_edge_timing_counter;

  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int SYNC = 3;
  localparam int MAX  = (1 << W) - 1;

  logic CLK;
  logic R;

  edge_timing_counter_if #(.CH(CH), .W(W)) bif ();

  edge_timing_counter #(.CH(CH), .W(W), .SYNC(SYNC)) u_dut (
    .CLK (CLK),
    .R   (R),
    .bus (bif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int ntest = 0;
  int nfail = 0;

  logic       en_v;
  logic       sat_v;
  logic [1:0] mode_v;

  logic [CH-1:0] xq[$];
  int unsigned   m_cnt[CH];
  int unsigned   m_per[CH];
  int unsigned   m_el[CH];
  bit            m_seen[CH];
  bit            m_pv[CH];
  bit            m_ovf[CH];

  logic [CH-1:0]   e_q, e_edge, e_pv, e_ovf;
  logic [CH*W-1:0] e_cnt, e_per;

  function automatic bit ev_of(bit q, bit p, logic [1:0] m);
    case (m)
      2'b00:   return q && !p;
      2'b01:   return !q && p;
      2'b10:   return q != p;
      default: return q;
    endcase
  endfunction

  task automatic model_reset();
    xq.delete();
    for (int k = 0; k <= SYNC; k++) xq.push_back('0);
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_per[i] = 0; m_el[i] = 0;
      m_seen[i] = 0; m_pv[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] qv, pv;
    if (!R) begin
      model_reset();
      return;
    end
    qv = xq[SYNC-1];
    pv = xq[SYNC];
    for (int i = 0; i < CH; i++) begin
      bit ev;
      ev = ev_of(qv[i], pv[i], bif.MODE);
      if (bif.CLR) begin
        m_cnt[i] = 0; m_per[i] = 0; m_el[i] = 0;
        m_seen[i] = 0; m_pv[i] = 0; m_ovf[i] = 0;
      end else if (bif.EN) begin
        if (ev) begin
          if (bif.SAT) begin
            if (m_cnt[i] == MAX) m_ovf[i] = 1;
            else m_cnt[i]++;
          end else begin
            m_cnt[i] = (m_cnt[i] + 1) % (MAX + 1);
            if (m_cnt[i] == 0) m_ovf[i] = 1;
          end
          m_per[i] = (m_el[i] + 1 > MAX) ? MAX : m_el[i] + 1;
          m_el[i] = 0;
          if (m_seen[i]) m_pv[i] = 1;
          m_seen[i] = 1;
        end else begin
          m_el[i]++;
        end
      end
    end
    xq.push_front(bif.X);
    void'(xq.pop_back());
  endtask

  task automatic model_expect();
    logic [CH-1:0] qv, pv;
    qv = xq[SYNC-1];
    pv = xq[SYNC];
    for (int i = 0; i < CH; i++) begin
      e_q[i]    = qv[i];
      e_edge[i] = R && bif.EN && ev_of(qv[i], pv[i], bif.MODE);
      e_pv[i]   = m_pv[i];
      e_ovf[i]  = m_ovf[i];
      e_cnt[i*W +: W] = W'(m_cnt[i]);
      e_per[i*W +: W] = W'(m_per[i]);
    end
  endtask

  task automatic tick(input logic [CH-1:0] x, input logic clr);
    bif.X    = x;
    bif.CLR  = clr;
    bif.EN   = en_v;
    bif.SAT  = sat_v;
    bif.MODE = mode_v;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    model_expect();
  endtask

  task automatic test_reset();
    R = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick('0, 1'b0);
      ntest++;
      if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !== '0) begin
        nfail++;
        $display("FAIL reset got Q=%b EDGE=%b PV=%b OVF=%b CNT=%h PER=%h exp all 0",
                 bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER);
      end
    end
    R = 1'b1;
  endtask

  task automatic test_rise();
    int nedge = 0;
    mode_v = 2'b00; en_v = 1'b1; sat_v = 1'b0;
    tick('0, 1'b1);
    for (int k = 0; k < 36; k++) begin
      tick((k < 30 && (k % 10) < 3) ? 2'b01 : 2'b00, 1'b0);
      if (bif.EDGE[0]) nedge++;
      ntest++;
      if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !==
          {e_q, e_edge, e_pv, e_ovf, e_cnt, e_per}) begin
        nfail++;
        $display("FAIL rise k=%0d got Q=%b E=%b PV=%b O=%b C=%h P=%h exp Q=%b E=%b PV=%b O=%b C=%h P=%h",
                 k, bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER,
                 e_q, e_edge, e_pv, e_ovf, e_cnt, e_per);
      end
    end
    ntest++;
    if (bif.CNT[0 +: W] !== 4'd3 || bif.PER[0 +: W] !== 4'd10 ||
        bif.PV[0] !== 1'b1 || bif.CNT[W +: W] !== 4'd0 || nedge != 3) begin
      nfail++;
      $display("FAIL rise_final got CNT0=%0d PER0=%0d PV0=%b CNT1=%0d edges=%0d exp 3 10 1 0 3",
               bif.CNT[0 +: W], bif.PER[0 +: W], bif.PV[0], bif.CNT[W +: W], nedge);
    end
  endtask

  task automatic test_both_level();
    logic [3:0] c_before;
    mode_v = 2'b10;
    tick('0, 1'b1);
    for (int k = 0; k < 25; k++) begin
      tick((k < 20 && ((k / 5) % 2 == 0)) ? 2'b10 : 2'b00, 1'b0);
      if (k == 24) mode_v = 2'b11;
      ntest++;
      if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !==
          {e_q, e_edge, e_pv, e_ovf, e_cnt, e_per}) begin
        nfail++;
        $display("FAIL both k=%0d got E=%b C=%h P=%h PV=%b exp E=%b C=%h P=%h PV=%b",
                 k, bif.EDGE, bif.CNT, bif.PER, bif.PV, e_edge, e_cnt, e_per, e_pv);
      end
    end
    c_before = bif.CNT[W +: W];
    for (int k = 0; k < 15; k++) begin
      tick((k >= 3 && k < 9) ? 2'b10 : 2'b00, 1'b0);
      ntest++;
      if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !==
          {e_q, e_edge, e_pv, e_ovf, e_cnt, e_per}) begin
        nfail++;
        $display("FAIL level k=%0d got E=%b C=%h P=%h PV=%b exp E=%b C=%h P=%h PV=%b",
                 k, bif.EDGE, bif.CNT, bif.PER, bif.PV, e_edge, e_cnt, e_per, e_pv);
      end
    end
    ntest++;
    if (c_before !== 4'd4 || bif.CNT[W +: W] !== 4'd10 ||
        bif.PER[W +: W] !== 4'd1 || bif.CNT[0 +: W] !== 4'd0) begin
      nfail++;
      $display("FAIL both_final got CNT1 %0d->%0d PER1=%0d CNT0=%0d exp 4->10 1 0",
               c_before, bif.CNT[W +: W], bif.PER[W +: W], bif.CNT[0 +: W]);
    end
  endtask

  task automatic test_wrap();
    for (int s = 0; s < 2; s++) begin
      mode_v = 2'b00;
      sat_v  = s[0];
      tick('0, 1'b1);
      for (int k = 0; k < 17 * 4 + 6; k++) begin
        tick((k < 68 && (k % 4) < 2) ? 2'b01 : 2'b00, 1'b0);
        ntest++;
        if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !==
            {e_q, e_edge, e_pv, e_ovf, e_cnt, e_per}) begin
          nfail++;
          $display("FAIL wrap sat=%0d k=%0d got C=%h O=%b P=%h exp C=%h O=%b P=%h",
                   s, k, bif.CNT, bif.OVF, bif.PER, e_cnt, e_ovf, e_per);
        end
      end
      ntest++;
      if (bif.CNT[0 +: W] !== (s ? 4'd15 : 4'd1) || bif.OVF[0] !== 1'b1) begin
        nfail++;
        $display("FAIL wrap_final sat=%0d got CNT0=%0d OVF0=%b exp %0d 1",
                 s, bif.CNT[0 +: W], bif.OVF[0], s ? 15 : 1);
      end
    end
    sat_v = 1'b0;
  endtask

  task automatic test_clr_edge();
    bit found = 0;
    mode_v = 2'b00;
    tick('0, 1'b1);
    for (int k = 0; k < 12; k++) tick((k % 5) < 2 && k < 10 ? 2'b01 : 2'b00, 1'b0);
    for (int k = 0; k < 10 && !found; k++) begin
      tick(2'b01, 1'b0);
      if (bif.EDGE[0]) found = 1;
    end
    ntest++;
    if (!found || bif.PV[0] !== 1'b1 || bif.CNT[0 +: W] !== 4'd2) begin
      nfail++;
      $display("FAIL clr_pre got edge_seen=%0d PV0=%b CNT0=%0d exp 1 1 2",
               found, bif.PV[0], bif.CNT[0 +: W]);
    end
    tick(2'b01, 1'b1);
    ntest++;
    if (bif.CNT[0 +: W] !== 4'd0 || bif.PV[0] !== 1'b0 || bif.OVF[0] !== 1'b0) begin
      nfail++;
      $display("FAIL clr_same got CNT0=%0d PV0=%b OVF0=%b exp 0 0 0",
               bif.CNT[0 +: W], bif.PV[0], bif.OVF[0]);
    end
    for (int k = 0; k < 12; k++) begin
      tick((k >= 3 && k < 6) ? 2'b00 : 2'b01, 1'b0);
      ntest++;
      if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !==
          {e_q, e_edge, e_pv, e_ovf, e_cnt, e_per}) begin
        nfail++;
        $display("FAIL clr k=%0d got E=%b C=%h PV=%b P=%h exp E=%b C=%h PV=%b P=%h",
                 k, bif.EDGE, bif.CNT, bif.PV, bif.PER, e_edge, e_cnt, e_pv, e_per);
      end
    end
    ntest++;
    if (bif.CNT[0 +: W] !== 4'd1 || bif.PV[0] !== 1'b0) begin
      nfail++;
      $display("FAIL clr_after got CNT0=%0d PV0=%b exp 1 0",
               bif.CNT[0 +: W], bif.PV[0]);
    end
  endtask

  task automatic test_en();
    logic [CH*W-1:0] c_hold, p_hold;
    logic [7:0] dis_x;
    dis_x = 8'b0000_1011;
    mode_v = 2'b00; en_v = 1'b1;
    tick('0, 1'b1);
    for (int k = 1; k <= 9; k++) tick((k <= 2) ? 2'b01 : 2'b00, 1'b0);
    c_hold = bif.CNT;
    p_hold = bif.PER;
    en_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick({1'b0, dis_x[k]}, 1'b0);
      ntest++;
      if (bif.EDGE !== '0 || bif.CNT !== c_hold || bif.PER !== p_hold ||
          bif.Q !== e_q) begin
        nfail++;
        $display("FAIL en_off k=%0d got E=%b C=%h P=%h Q=%b exp E=0 C=%h P=%h Q=%b",
                 k, bif.EDGE, bif.CNT, bif.PER, bif.Q, c_hold, p_hold, e_q);
      end
    end
    en_v = 1'b1;
    for (int k = 18; k <= 27; k++) begin
      tick((k == 21 || k == 22) ? 2'b01 : 2'b00, 1'b0);
      ntest++;
      if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !==
          {e_q, e_edge, e_pv, e_ovf, e_cnt, e_per}) begin
        nfail++;
        $display("FAIL en_on k=%0d got E=%b C=%h P=%h PV=%b exp E=%b C=%h P=%h PV=%b",
                 k, bif.EDGE, bif.CNT, bif.PER, bif.PV, e_edge, e_cnt, e_per, e_pv);
      end
    end
    ntest++;
    if (bif.CNT[0 +: W] !== 4'd2 || bif.PER[0 +: W] !== 4'd12 || bif.PV[0] !== 1'b1) begin
      nfail++;
      $display("FAIL en_final got CNT0=%0d PER0=%0d PV0=%b exp 2 12 1",
               bif.CNT[0 +: W], bif.PER[0 +: W], bif.PV[0]);
    end
  endtask

  task automatic test_async_reset();
    mode_v = 2'b11;
    tick('0, 1'b1);
    for (int k = 0; k < 20; k++) tick(2'b10, 1'b0);
    mode_v = 2'b00;
    for (int k = 0; k < 26; k++) tick((k < 20 && (k % 4) < 2) ? 2'b01 : 2'b00, 1'b0);
    ntest++;
    if (bif.CNT[0 +: W] !== 4'd5 || bif.OVF[1] !== 1'b1) begin
      nfail++;
      $display("FAIL arst_pre got CNT0=%0d OVF1=%b exp 5 1",
               bif.CNT[0 +: W], bif.OVF[1]);
    end
    #2 R = 1'b0;
    #1;
    model_reset();
    ntest++;
    if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !== '0) begin
      nfail++;
      $display("FAIL arst_now got Q=%b E=%b PV=%b O=%b C=%h P=%h exp all 0",
               bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER);
    end
    R = 1'b1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick(2'b01, 1'b0);
      ntest++;
      if (bif.CNT[0 +: W] !== ((k == SYNC + 1) ? 4'd1 : 4'd0) ||
          bif.CNT !== e_cnt) begin
        nfail++;
        $display("FAIL arst_resume edge=%0d got CNT0=%0d exp %0d",
                 k, bif.CNT[0 +: W], (k == SYNC + 1) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] x = '0;
    tick('0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      if (k % 25 == 0) begin
        mode_v = 2'($urandom_range(0, 3));
        sat_v  = 1'($urandom_range(0, 1));
      end
      en_v = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 2) == 0) x[i] = ~x[i];
      tick(x, $urandom_range(0, 59) == 0);
      if (k == 200) begin
        #2 R = 1'b0;
        #1 model_reset();
        model_expect();
        R = 1'b1;
      end
      ntest++;
      if ({bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER} !==
          {e_q, e_edge, e_pv, e_ovf, e_cnt, e_per}) begin
        nfail++;
        $display("FAIL random k=%0d got Q=%b E=%b PV=%b O=%b C=%h P=%h exp Q=%b E=%b PV=%b O=%b C=%h P=%h",
                 k, bif.Q, bif.EDGE, bif.PV, bif.OVF, bif.CNT, bif.PER,
                 e_q, e_edge, e_pv, e_ovf, e_cnt, e_per);
      end
    end
  endtask

  initial begin
    en_v = 1'b1; sat_v = 1'b0; mode_v = 2'b00;
    bif.X = '0; bif.EN = 1'b1; bif.CLR = 1'b0;
    bif.SAT = 1'b0; bif.MODE = 2'b00;
    test_reset();
    test_rise();
    test_both_level();
    test_wrap();
    test_clr_edge();
    test_en();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
